// File: rtl/rect_plot_pkg.sv
// Shared definitions for the rectangle plot arbiter: FSM encoding, screen
// defaults and pixel-port coordinate widths.
package rect_plot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int DIM_W = 4;
    localparam int COL_W = 3;
    // Wide enough that bx+cx / by+cy never wrap, so clipping can see overflow.
    localparam int SUM_W = 9;

endpackage

// File: rtl/rect_scan.sv
// Row-major pixel offset scanner for one rectangle: cx runs 0..w within a
// row, cy runs 0..h; last flags the final pixel.
module rect_scan
    import rect_plot_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    output logic [DIM_W-1:0] cx,
    output logic [DIM_W-1:0] cy,
    output logic             last
);

    logic [DIM_W-1:0] cx_q, cx_d;
    logic [DIM_W-1:0] cy_q, cy_d;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (start) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step) begin
            if (cx_q == w) begin
                cx_d = '0;
                cy_d = (cy_q == h) ? '0 : cy_q + DIM_W'(1);
            end else begin
                cx_d = cx_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = (cx_q == w) && (cy_q == h);

endmodule

// File: rtl/rect_plot_arbiter.sv
// Round-robin arbiter that lets NUM_REQ rectangle requesters share one VGA
// pixel port, filling each granted rectangle one clipped pixel per cycle.
module rect_plot_arbiter
    import rect_plot_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [X_W*NUM_REQ-1:0]     rect_x,
    input  logic [Y_W*NUM_REQ-1:0]     rect_y,
    input  logic [DIM_W*NUM_REQ-1:0]   rect_w,
    input  logic [DIM_W*NUM_REQ-1:0]   rect_h,
    input  logic [COL_W*NUM_REQ-1:0]   rect_colour,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [X_W-1:0]             x,
    output logic [Y_W-1:0]             y,
    output logic [COL_W-1:0]           colour,
    output logic                       plot,
    output logic                       busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SUM_W-1:0] SCR_W9 = SUM_W'(SCREEN_W);
    localparam logic [SUM_W-1:0] SCR_H9 = SUM_W'(SCREEN_H);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [X_W-1:0]     bx_q, bx_d;
    logic [Y_W-1:0]     by_q, by_d;
    logic [DIM_W-1:0]   bw_q, bw_d;
    logic [DIM_W-1:0]   bh_q, bh_d;
    logic [COL_W-1:0]   bcol_q, bcol_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COL_W-1:0]   colour_q, colour_d;
    logic               plot_q, plot_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               scan_start, scan_step, scan_last;
    logic [DIM_W-1:0]   cx, cy;
    logic [SUM_W-1:0]   sum_x, sum_y;

    rect_scan u_scan (
        .clock (clock),
        .reset (reset),
        .start (scan_start),
        .step  (scan_step),
        .w     (bw_q),
        .h     (bh_q),
        .cx    (cx),
        .cy    (cy),
        .last  (scan_last)
    );

    // First requester at or after rr, wrapping, wins.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_q) + i) % NUM_REQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    assign sum_x = SUM_W'(bx_q) + SUM_W'(cx);
    assign sum_y = SUM_W'(by_q) + SUM_W'(cy);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        win_d      = win_q;
        bx_d       = bx_q;
        by_d       = by_q;
        bw_d       = bw_q;
        bh_d       = bh_q;
        bcol_d     = bcol_q;
        gnt_d      = '0;
        done_d     = '0;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        scan_start = 1'b0;
        scan_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    win_d          = win_idx;
                    bx_d           = rect_x[int'(win_idx)*X_W +: X_W];
                    by_d           = rect_y[int'(win_idx)*Y_W +: Y_W];
                    bw_d           = rect_w[int'(win_idx)*DIM_W +: DIM_W];
                    bh_d           = rect_h[int'(win_idx)*DIM_W +: DIM_W];
                    bcol_d         = rect_colour[int'(win_idx)*COL_W +: COL_W];
                    gnt_d[win_idx] = 1'b1;
                    scan_start     = 1'b1;
                    state_d        = ST_DRAW;
                end
            end
            ST_DRAW: begin
                // Off-screen pixels still take their cycle, just without plot.
                x_d       = sum_x[X_W-1:0];
                y_d       = sum_y[Y_W-1:0];
                colour_d  = bcol_q;
                plot_d    = (sum_x < SCR_W9) && (sum_y < SCR_H9);
                scan_step = 1'b1;
                if (scan_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d[win_q] = 1'b1;
                rr_d          = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + IDX_W'(1);
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            win_q    <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            bw_q     <= '0;
            bh_q     <= '0;
            bcol_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            bw_q     <= bw_d;
            bh_q     <= bh_d;
            bcol_q   <= bcol_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rect_plot_arbiter.sv
// Scoreboard bench for rect_plot_arbiter: a transaction-level model queues
// timed gnt/plot/done events and a negedge monitor checks the DUT against them.
module tb_rect_plot_arbiter;

    localparam int NR = 4;
    localparam int SW = 160;
    localparam int SH = 120;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req   = '0;
    logic [8*NR-1:0] rect_x = '0;
    logic [7*NR-1:0] rect_y = '0;
    logic [4*NR-1:0] rect_w = '0;
    logic [4*NR-1:0] rect_h = '0;
    logic [3*NR-1:0] rect_colour = '0;
    logic [NR-1:0]   gnt, done;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      colour;
    logic            plot, busy;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int m_rr   = 0;
    int px[NR], py[NR], pw[NR], ph[NR], pc[NR];

    // kind: 0 = gnt, 1 = visible pixel, 2 = done
    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;
    ev_t q[$];

    rect_plot_arbiter #(.NUM_REQ(NR), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clock       (clk),
        .reset       (reset),
        .req         (req),
        .rect_x      (rect_x),
        .rect_y      (rect_y),
        .rect_w      (rect_w),
        .rect_h      (rect_h),
        .rect_colour (rect_colour),
        .gnt         (gnt),
        .done        (done),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(int k, int c, int d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        q.push_back(e);
    endfunction

    function automatic int pix(int px_v, int py_v, int col);
        return (px_v << 10) | (py_v << 3) | col;
    endfunction

    function automatic int idx_of(logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction-level expectation: from the first grant cycle t0, serve the
    // pending set round-robin; each rectangle is 1 grant, (w+1)(h+1) pixel
    // cycles, 1 done cycle, with the next grant one cycle after done.
    function automatic void model(int t0, logic [NR-1:0] mask, bit held, int k);
        int t, n, win;
        logic [NR-1:0] pend;
        t = t0;
        n = 0;
        pend = mask;
        while (pend != 0 && (!held || n < k)) begin
            win = -1;
            for (int i = 0; i < NR; i++)
                if (win < 0 && pend[(m_rr + i) % NR]) win = (m_rr + i) % NR;
            push_ev(0, t, win);
            for (int r = 0; r <= ph[win]; r++) begin
                for (int c = 0; c <= pw[win]; c++) begin
                    t++;
                    if (px[win] + c < SW && py[win] + r < SH)
                        push_ev(1, t, pix(px[win] + c, py[win] + r, pc[win]));
                end
            end
            t++;
            push_ev(2, t, win);
            m_rr = (win + 1) % NR;
            if (!held) pend[win] = 1'b0;
            n++;
            t++;
        end
    endfunction

    always @(negedge clk) begin
        int nobs, k, d;
        ev_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missing event (kind)", -1, q[0].kind);
            void'(q.pop_front());
        end
        nobs = int'(gnt != 0) + int'(done != 0) + int'(plot);
        if (nobs > 1) begin
            chk("one event per cycle", nobs, 1);
        end else if (nobs == 1) begin
            if (gnt != 0) begin
                k = 0;
                d = idx_of(gnt);
                chk("gnt one-hot", int'($onehot(gnt)), 1);
            end else if (done != 0) begin
                k = 2;
                d = idx_of(done);
                chk("done one-hot", int'($onehot(done)), 1);
            end else begin
                k = 1;
                d = pix(int'(x), int'(y), int'(colour));
            end
            if (k != 2) chk("busy while active", int'(busy), 1);
            if (q.size() == 0) begin
                chk("unexpected event (kind)", k, -1);
            end else begin
                e = q.pop_front();
                chk("event kind", k, e.kind);
                chk("event cycle", cyc, e.cyc);
                chk("event data", d, e.data);
            end
        end
    end

    task automatic set_param(input int i, input int xv, input int yv,
                             input int wv, input int hv, input int cv);
        px[i] = xv; py[i] = yv; pw[i] = wv; ph[i] = hv; pc[i] = cv;
    endtask

    task automatic drive_params();
        for (int i = 0; i < NR; i++) begin
            rect_x[i*8 +: 8]      = 8'(px[i]);
            rect_y[i*7 +: 7]      = 7'(py[i]);
            rect_w[i*4 +: 4]      = 4'(pw[i]);
            rect_h[i*4 +: 4]      = 4'(ph[i]);
            rect_colour[i*3 +: 3] = 3'(pc[i]);
        end
    endtask

    task automatic rand_params();
        for (int i = 0; i < NR; i++)
            set_param(i, int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 7)));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " gnt"}, int'(gnt), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " plot"}, int'(plot), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " x"}, int'(x), 0);
        chk({tag, " y"}, int'(y), 0);
        chk({tag, " colour"}, int'(colour), 0);
    endtask

    // held=1: requesters keep req until k grants seen; held=0: each requester
    // drops req right after its grant, optionally scrambling its parameters.
    task automatic run(input logic [NR-1:0] mask, input bit held, input int k, input bit perturb);
        int ngr, budget;
        drive_params();
        @(posedge clk); #1;
        req = mask;
        model(cyc + 1, mask, held, k);
        ngr = 0;
        budget = 0;
        while ((q.size() != 0 || busy || req != 0) && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
            if (gnt != 0) begin
                ngr++;
                if (held) begin
                    if (ngr >= k) req = '0;
                end else begin
                    req = req & ~gnt;
                    if (perturb) begin
                        for (int i = 0; i < NR; i++) begin
                            if (gnt[i]) begin
                                rect_x[i*8 +: 8]      = 8'($urandom);
                                rect_colour[i*3 +: 3] = 3'($urandom);
                            end
                        end
                    end
                end
            end
        end
        if (budget >= 3000) begin
            chk("scenario timeout", budget, 0);
            q.delete();
            req = '0;
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] m;
        int t0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        q.delete();
        m_rr = 0;
        check_idle_outputs("reset");
        reset = 1'b0;

        // All four requesting 1x1 rectangles: grants 0,1,2,3,0.
        for (int i = 0; i < NR; i++) set_param(i, 20 * i, 10 + i, 0, 0, i + 1);
        run(4'b1111, 1'b1, 5, 1'b0);

        set_param(2, 10, 20, 1, 1, 6);
        run(4'b0100, 1'b0, 1, 1'b0);

        // Bottom-right corner: only two of eight pixels on screen.
        set_param(1, 158, 119, 3, 1, 2);
        run(4'b0010, 1'b0, 1, 1'b0);

        set_param(3, 0, 0, 15, 15, 7);
        run(4'b1000, 1'b0, 1, 1'b0);

        set_param(0, 40, 50, 2, 2, 5);
        run(4'b0001, 1'b0, 1, 1'b1);

        // Reset during the third pixel cycle of a 4x4 rectangle.
        set_param(0, 5, 5, 3, 3, 3);
        set_param(1, 30, 40, 2, 1, 5);
        drive_params();
        @(posedge clk); #1;
        req = 4'b0001;
        t0 = cyc + 1;
        model(t0, 4'b0001, 1'b0, 1);
        while (cyc < t0 + 3) begin
            @(posedge clk); #1;
            req = req & ~gnt;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        q.delete();
        m_rr = 0;
        chk("mid-draw reset plot", int'(plot), 0);
        chk("mid-draw reset busy", int'(busy), 0);
        chk("mid-draw reset done", int'(done), 0);
        reset = 1'b0;
        run(4'b0010, 1'b0, 1, 1'b0);

        for (int s = 0; s < 16; s++) begin
            rand_params();
            m = NR'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0)
                run(m, 1'b1, int'($urandom_range(1, 6)), 1'b0);
            else
                run(m, 1'b0, 1, 1'b1);
        end

        chk("scoreboard drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_plot_arbiter.md
RECT_PLOT_ARBITER -- requirements
Module: rect_plot_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of rectangle-draw requesters sharing the single VGA pixel port.
REQ-002 Parameter SCREEN_W, default 160, visible columns; SCREEN_H, default 120, visible rows.
REQ-003 clock  input  1  system clock (CLOCK_50); the only clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester draw request, level, held until matching done.
REQ-006 rect_x  input  8*NUM_REQ  per-requester top-left column.
REQ-007 rect_y  input  7*NUM_REQ  per-requester top-left row.
REQ-008 rect_w, rect_h  input  4*NUM_REQ each  per-requester size minus one (0..15 gives 1..16 pixels).
REQ-009 rect_colour  input  3*NUM_REQ  per-requester 3-bit RGB fill.
REQ-010 gnt  output  NUM_REQ  one-hot, one-cycle pulse: parameters latched.
REQ-011 done  output  NUM_REQ  one-hot, one-cycle pulse: last pixel issued.
REQ-012 x  output  8, y  output  7, colour  output  3, plot  output  1: to vga_adapter pixel port.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, DRAW, DONE; all outputs registered.
REQ-015 IDLE, req==0: stay in IDLE; plot=0.
REQ-016 IDLE, any req high: select winner by round-robin from pointer rr; latch winner's x, y, w, h, colour; pulse gnt[winner]; go to DRAW next cycle.
REQ-017 Round-robin: search starts at rr, ascending, wrapping NUM_REQ-1 to 0; rr=0 after reset.
REQ-018 DRAW: each cycle output x=bx+cx, y=by+cy, colour=latched colour; cx,cy start at 0.
REQ-019 Scan order row-major: cx increments; when cx==w, cx->0 and cy increments.
REQ-020 When cx==w and cy==h, that pixel is the last; go to DONE next cycle.
REQ-021 DONE: pulse done[winner], plot=0, rr=winner+1 mod NUM_REQ, return to IDLE.
REQ-022 Cycle count per rectangle: 1 grant + (w+1)*(h+1) draw + 1 done; back-to-back requests re-arbitrate in IDLE (1 idle cycle minimum).
REQ-023 Address sums computed 9-bit; pixel with sum column >=SCREEN_W or row >=SCREEN_H drives plot=0 but still consumes its cycle (clipping, no wrap-around).
REQ-024 Latched parameters are immune to requester changes; dropping req during DRAW does not abort; done still pulses.
REQ-025 New req arriving during DRAW/DONE waits; never preempts.
REQ-026 gnt and done never asserted in the same cycle; at most one bit of each high.

Reset
REQ-027 On reset: state=IDLE, rr=0, cx=cy=0, gnt=0, done=0, plot=0, x=0, y=0, colour=0, busy=0, effective at the next edge.
REQ-028 Reset mid-DRAW aborts the rectangle: no done pulse; plot=0 from next edge.

Structure
REQ-029 Shared package rect_plot_pkg holds FSM state encoding, SCREEN_W/SCREEN_H defaults, and coordinate widths (8-bit x, 7-bit y).
REQ-030 One sub-module rect_scan: holds cx/cy counters, inputs start, w, h, outputs cx, cy, last; arbitration and clipping stay in rect_plot_arbiter.

Verification
REQ-031 req[2] only, x=10,y=20,w=1,h=1,colour=6 -> gnt[2] cycle 1; plot at (10,20),(11,20),(10,21),(11,21) cycles 2-5, colour 6; done[2] cycle 6.
REQ-032 After reset, req=4'b1111 held, all w=h=0 -> grants in order 0,1,2,3,0; each done precedes next gnt.
REQ-033 x=158,y=119,w=3,h=1 -> 8 draw cycles; plot=1 only at (158,119),(159,119); done after 8th.
REQ-034 w=h=15 at (0,0) -> exactly 256 plot cycles, last (15,15); done next cycle.
REQ-035 reset asserted at 3rd draw cycle of a 4x4 rect -> plot=0, busy=0, no done; following req[1] gets gnt[1] (rr=0 search).
REQ-036 req[0] dropped after gnt, rect_x changed mid-draw -> all pixels use latched values; done[0] still pulses.
